// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer: state encoding,
// word layout and the power-up instruction table.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT_SEND = 3'd0,
    INIT_WAIT = 3'd1,
    INIT_DLY  = 3'd2,
    IDLE      = 3'd3,
    SEND      = 3'd4,
    WAIT_DONE = 3'd5,
    DLY       = 3'd6
  } state_t;

  localparam int WORD_W   = 9;
  localparam int RS_BIT   = 8;
  localparam int BYTE_MSB = 7;
  localparam int INIT_LEN = 5;
  localparam int IDX_W    = 3;

  // Function set 8-bit/2-line, display on, clear, entry mode, home line 1.
  function automatic logic [WORD_W-1:0] init_word(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    init_word = 9'h038;
      3'd1:    init_word = 9'h00C;
      3'd2:    init_word = 9'h001;
      3'd3:    init_word = 9'h006;
      3'd4:    init_word = 9'h080;
      default: init_word = 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-requester round-robin arbiter with a last-grant register.
// Grant is one-hot and only produced while i_en is high.
module lcd_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_last_b;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req[0] && i_req[1]) o_gnt = r_last_b ? 2'b01 : 2'b10;
      else                      o_gnt = i_req;
    end
  end

  // Reset to "B granted last" so A wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_last_b <= 1'b1;
    else if (|o_gnt) r_last_b <= o_gnt[1];
  end

endmodule

// File: rtl/lcd_sequencer.sv
// Sends the LCD power-up sequence, then serves two requesters one word at a
// time, with a fixed idle gap after every completed LCD command.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned DLY_MAX = 18'h3FFFE,
  parameter int unsigned CNT_W   = 18
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ_A,
  input  logic [8:0] iDATA_A,
  output logic       oACK_A,
  input  logic       iREQ_B,
  input  logic [8:0] iDATA_B,
  output logic       oACK_B,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  input  logic       iLCD_DONE,
  output logic       oREADY,
  output logic       oBUSY
);

  localparam logic [CNT_W-1:0] L_DLY_MAX = CNT_W'(DLY_MAX);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_data;
  logic               r_rs;
  logic               r_start;
  logic               r_ack_a;
  logic               r_ack_b;
  logic               r_ready;
  logic [1:0]         w_gnt;
  logic [WORD_W-1:0]  w_init;

  assign w_init = init_word(r_idx);

  lcd_rr_arb u_arb (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_en    (r_state == IDLE),
    .i_req   ({iREQ_B, iREQ_A}),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= INIT_SEND;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_start <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      case (r_state)
        INIT_SEND: begin
          r_data  <= w_init[BYTE_MSB:0];
          r_rs    <= w_init[RS_BIT];
          r_start <= 1'b1;
          r_state <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (iLCD_DONE) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= INIT_DLY;
          end
        end
        INIT_DLY: begin
          if (r_cnt == L_DLY_MAX) begin
            r_cnt <= '0;
            if (r_idx == IDX_W'(INIT_LEN - 1)) begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= INIT_SEND;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // Grant, data latch, ACK and START all land on the same edge.
        IDLE: begin
          if (w_gnt[0]) begin
            r_data  <= iDATA_A[BYTE_MSB:0];
            r_rs    <= iDATA_A[RS_BIT];
            r_ack_a <= 1'b1;
            r_start <= 1'b1;
            r_state <= SEND;
          end else if (w_gnt[1]) begin
            r_data  <= iDATA_B[BYTE_MSB:0];
            r_rs    <= iDATA_B[RS_BIT];
            r_ack_b <= 1'b1;
            r_start <= 1'b1;
            r_state <= SEND;
          end
        end
        SEND: r_state <= WAIT_DONE;
        WAIT_DONE: begin
          if (iLCD_DONE) begin
            r_start <= 1'b0;
            r_cnt   <= '0;
            r_state <= DLY;
          end
        end
        DLY: begin
          if (r_cnt == L_DLY_MAX) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= INIT_SEND;
      endcase
    end
  end

  assign oLCD_DATA  = r_data;
  assign oLCD_RS    = r_rs;
  assign oLCD_START = r_start;
  assign oACK_A     = r_ack_a;
  assign oACK_B     = r_ack_b;
  assign oREADY     = r_ready;
  assign oBUSY      = (r_state != IDLE);

endmodule

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 SHALL have parameter DLY_MAX, default 18'h3FFFE: inter-command idle cycles after each lcd completion.
REQ-002 SHALL have parameter CNT_W, default 18: width of the delay counter.
REQ-003 SHALL have port iCLK, input, 1: single clock, rising edge; one clock, all logic on it.
REQ-004 SHALL have port iRST_N, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port iREQ_A, input, 1: requester A (operand/result writer) wants a transfer.
REQ-006 SHALL have port iDATA_A, input, 9: A word; bit8 = RS (1 char, 0 instruction), bits7:0 = byte.
REQ-007 SHALL have port oACK_A, output, 1: one-cycle pulse, A word accepted.
REQ-008 SHALL have port iREQ_B, input, 1: requester B (text/status writer) wants a transfer.
REQ-009 SHALL have port iDATA_B, input, 9: B word, same format as iDATA_A.
REQ-010 SHALL have port oACK_B, output, 1: one-cycle pulse, B word accepted.
REQ-011 SHALL have port oLCD_DATA, output, 8: byte to lcd iDATA.
REQ-012 SHALL have port oLCD_RS, output, 1: to lcd iRS.
REQ-013 SHALL have port oLCD_START, output, 1: to lcd iStart.
REQ-014 SHALL have port iLCD_DONE, input, 1: from lcd oDone.
REQ-015 SHALL have port oREADY, output, 1: init sequence complete; requests are served.
REQ-016 SHALL have port oBUSY, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement states INIT_SEND, INIT_WAIT, INIT_DLY, IDLE, SEND, WAIT_DONE, DLY.
REQ-018 SHALL issue init words 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080 in order after reset, before serving any request.
REQ-019 SHALL, for each word (init or requested): drive oLCD_DATA/oLCD_RS and raise oLCD_START in the send state; hold all three stable until iLCD_DONE is sampled high; clear oLCD_START on the following edge; enter the delay state.
REQ-020 SHALL count the delay counter from 0 to DLY_MAX, then return to INIT_SEND (next init word), or to IDLE after the fifth init word or any requested word.
REQ-021 SHALL set oREADY high on the edge that enters IDLE after the fifth init word; it stays high until reset.
REQ-022 SHALL, in IDLE, sample iREQ_A/iREQ_B each edge; on a request, on that edge: latch the winner's data, pulse its oACK, assert oLCD_START, and enter SEND; latency from request seen to oLCD_START is one cycle.
REQ-023 SHALL arbitrate simultaneous requests round-robin: the grant goes to the requester not granted last.
REQ-024 SHALL give A priority on the first tie after reset.
REQ-025 SHALL ignore requests outside IDLE, including during init; requesters hold iREQ and data until oACK.
REQ-026 SHALL never assert oACK_A and oACK_B in the same cycle.
REQ-027 SHALL never re-grant a requester from the same oACK cycle; oACK is only generated from IDLE.
REQ-028 SHALL treat iLCD_DONE outside WAIT_DONE/INIT_WAIT as don't-care.
REQ-029 SHALL take a DLY_MAX of 0 as a one-cycle delay state.

Reset
REQ-030 SHALL, on iRST_N low (asynchronous): enter INIT_SEND with init index 0 and delay counter 0, last-grant = B (so A wins the first tie).
REQ-031 SHALL drive these output values while iRST_N is low: oLCD_DATA=0, oLCD_RS=0, oLCD_START=0, oACK_A=0, oACK_B=0, oREADY=0, oBUSY=1.
REQ-032 SHALL, on a reset mid-transfer: abort the transfer; not ACK the pending word; restart init in full after release.

Structure
REQ-033 SHALL place state encoding, the init-word table, the 9-bit word field positions (RS bit index) and init length 5 in shared package lcd_pkg.
REQ-034 SHALL implement the arbiter as sub-module lcd_rr_arb (two requests, last-grant register, one-hot grant).
REQ-035 SHALL not instantiate lcd itself; control_unit wires lcd_sequencer to lcd.

Verification (DLY_MAX=4, lcd model asserts oDone 3 cycles after iStart)
REQ-036 SHALL test reset release: exactly 5 oLCD_START rising edges with data 38,0C,01,06,80 and RS=0, then oREADY=1; ≥5 delay cycles between each.
REQ-037 SHALL test iREQ_A high with 9'h141 after oREADY: oACK_A pulses one cycle, next cycle oLCD_DATA=8'h41, oLCD_RS=1, oLCD_START=1 until done.
REQ-038 SHALL test iREQ_A and iREQ_B held high together, three transfers each: grants alternate A,B,A,B,A,B; the two oACKs never overlap.
REQ-039 SHALL test iREQ_B=1 during init: no oACK_B before oREADY; B is served first after oREADY.
REQ-040 SHALL test iRST_N low during WAIT_DONE of a requested word: outputs reach their reset values immediately; no oACK for that word; after release the full init replays; oREADY=0 until it ends.
